// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one- or two-byte instructions from a byte-wide
// program memory with one-cycle read latency and hands them to decode.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic [7:0] instr,
  output logic [7:0] imm,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  output logic       halted
);

  typedef enum logic [2:0] {
    F0_REQ,
    F0_CAP,
    F1_REQ,
    F1_CAP,
    VALID,
    HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] instr_pc_q, instr_pc_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    instr_pc_d  = instr_pc_q;
    mem_rd      = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    case (state_q)
      F0_REQ: begin
        mem_rd     = 1'b1;
        instr_pc_d = pc_q;
        pc_d       = pc_q + 8'd1;
        state_d    = F0_CAP;
      end
      F0_CAP: begin
        instr_d = mem_rdata;
        // Opcode classes 9x and Dx carry an immediate byte
        if (mem_rdata[7:4] == 4'b1001 || mem_rdata[7:4] == 4'b1101) begin
          state_d = F1_REQ;
        end else begin
          imm_d   = 8'h00;
          state_d = VALID;
        end
      end
      F1_REQ: begin
        mem_rd  = 1'b1;
        pc_d    = pc_q + 8'd1;
        state_d = F1_CAP;
      end
      F1_CAP: begin
        imm_d   = mem_rdata;
        state_d = VALID;
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_d = (instr_q[7:4] == 4'b1111) ? HALT : F0_REQ;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = F0_REQ;
      end
    endcase

    // A redirect loses only to an accepted HLT (or an existing halt)
    if (jump_en && state_q != HALT && state_d != HALT) begin
      pc_d    = jump_addr;
      state_d = F0_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F0_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= 8'h00;
      imm_q      <= 8'h00;
      instr_pc_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_addr = pc_q;
  assign instr    = instr_q;
  assign imm      = imm_q;
  assign instr_pc = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked each
// cycle against an instruction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [7:0] RST_PC = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] instr, imm, instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic       halted;

  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  // Model: current instruction starts at ma, mk cycles since fetch began,
  // ml = cycles until valid (2 or 4), mh = halted.
  logic [7:0] ma;
  int         mk;
  int         ml;
  bit         mh;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .imm        (imm),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat(input logic [7:0] op);
    return (op[7:4] == 4'h9 || op[7:4] == 4'hD) ? 4 : 2;
  endfunction

  task automatic start(input logic [7:0] addr);
    ma = addr;
    mk = 0;
    ml = lat(mem[addr]);
  endtask

  task automatic check();
    logic [7:0] ea;
    logic [7:0] nx;
    bit         ev;
    if (mh) begin
      chk("halted_h", {7'd0, halted}, 8'd1);
      chk("rd_h", {7'd0, mem_rd}, 8'd0);
      chk("valid_h", {7'd0, instr_valid}, 8'd0);
      chk("addr_h", mem_addr, ma + 8'd1);
    end else begin
      ev = (mk >= ml);
      ea = ma;
      if (mk >= 1) ea = ea + 8'd1;
      if (ml == 4 && mk >= 3) ea = ea + 8'd1;
      chk("halted", {7'd0, halted}, 8'd0);
      chk("valid", {7'd0, instr_valid}, {7'd0, ev});
      chk("rd", {7'd0, mem_rd}, {7'd0, (mk == 0) || (ml == 4 && mk == 2)});
      chk("addr", mem_addr, ea);
      if (ev) begin
        nx = ma + 8'd1;
        chk("instr", instr, mem[ma]);
        chk("imm", imm, (ml == 4) ? mem[nx] : 8'h00);
        chk("instr_pc", instr_pc, ma);
      end
    end
  endtask

  task automatic cycle(input bit j, input logic [7:0] ja, input bit rdy);
    jump_en = j;
    jump_addr = ja;
    instr_ready = rdy;
    @(posedge clk);
    if (!mh) begin
      if (mk >= ml && rdy) begin
        if (mem[ma][7:4] == 4'hF) mh = 1'b1;
        else if (j) start(ja);
        else start(ma + 8'(ml / 2));
      end else if (j) begin
        start(ja);
      end else if (mk < ml) begin
        mk++;
      end
    end
    @(negedge clk);
    check();
    $display("cycle t=%0t rdy=%0b jmp=%0b ja=%h valid=%0b instr=%h imm=%h pc=%h addr=%h rd=%0b halted=%0b",
             $time, rdy, j, ja, instr_valid, instr, imm, instr_pc, mem_addr, mem_rd, halted);
  endtask

  // Reset is raised between edges to exercise its asynchronous effect.
  task automatic do_reset();
    jump_en = 1'b0;
    instr_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_instr", instr, 8'h00);
    chk("rst_imm", imm, 8'h00);
    chk("rst_ipc", instr_pc, 8'h00);
    chk("rst_valid", {7'd0, instr_valid}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_addr", mem_addr, RST_PC);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mh = 1'b0;
    start(RST_PC);
    check();
    $display("reset t=%0t addr=%h", $time, mem_addr);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic wait_valid();
    while (!mh && mk < ml) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    fill_random();
    mem[8'hFF] = 8'hD8; mem[8'h00] = 8'h77;
    mem[8'h01] = 8'h14; mem[8'h02] = 8'h28;
    mem[8'h03] = 8'h94; mem[8'h04] = 8'h3C;
    mem[8'h05] = 8'hD1; mem[8'h06] = 8'h55;
    mem[8'h07] = 8'hF0;
    mem[8'h40] = 8'h2A; mem[8'h41] = 8'h91; mem[8'h42] = 8'h07; mem[8'h43] = 8'h11;
    mem[8'h90] = 8'hF0;
    @(negedge clk);

    // Wrapping two-byte fetch from 0xFF, then a run ending in HLT
    do_reset();
    repeat (30) cycle(1'b0, 8'h00, 1'b1);
    repeat (3) cycle(1'b1, 8'h40, 1'b1);

    // Reset out of HALT, then a five-cycle stall on a valid instruction
    do_reset();
    wait_valid();
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Redirect during the immediate capture of a two-byte instruction
    do_reset();
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h40, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1);

    // Redirect coinciding with a transfer, then with an HLT transfer
    wait_valid();
    cycle(1'b1, 8'h90, 1'b1);
    wait_valid();
    cycle(1'b1, 8'h20, 1'b1);
    repeat (4) cycle(1'($urandom_range(0, 1)), 8'h33, 1'b1);
    do_reset();
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // One-byte pair at 0x00
    mem[8'h00] = 8'h14; mem[8'h01] = 8'h28; mem[8'h02] = 8'hF0;
    do_reset();
    cycle(1'b1, 8'h00, 1'b1);
    repeat (10) cycle(1'b0, 8'h00, 1'b1);

    // Two-byte instruction at 0x00
    mem[8'h00] = 8'h94; mem[8'h01] = 8'h3C; mem[8'h02] = 8'hF0;
    do_reset();
    cycle(1'b1, 8'h00, 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with stalls, redirects and resets
    fill_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ((mh && r < 20) || r == 0) begin
        if (r == 0) fill_random();
        do_reset();
      end else begin
        cycle(r < 6, 8'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
